clic_preempt_ctrl: RTL and testbench
====================================

// Module: clic_preempt_ctrl
// PURPOSE
//  Sequences interrupt entry/exit between n_clic and the core datapath. Accepts the
//  highest pending request and redirects the PC to its vector. Selects the register
//  bank level (rf.regs[level]) and claims the entry so its pend bit clears.
//  Keeps a LIFO of {prev_level, return_pc} so nested preemptions unwind in order.
// PARAMETERS
//  PrioWidth   3             level width; bank count = 2**PrioWidth
//  IdWidth     3             vector/entry index width
//  StackDepth  7             LIFO entries (2**PrioWidth-1 covers strict nesting)
//  RetSentinel 32'hFFFF_FFFF value written to ra on entry; jalr to it = return
// PORTS
//  clk           in   1          clock
//  reset         in   1          asynchronous, active-low reset (0 = in reset)
//  req_valid     in   1          n_clic has an enabled+pended entry
//  req_level     in   PrioWidth  priority of that entry
//  req_id        in   IdWidth    entry index
//  req_vec       in   32         vector (ISR byte address)
//  pc_return     in   32         PC of the oldest not-yet-executed instruction
//  ret_valid     in   1          decoder: jalr target == RetSentinel
//  stall         in   1          core cannot redirect this cycle
//  take          out  1          1-cycle pulse: entry accepted
//  pc_redirect   out  1          PC mux select this cycle
//  pc_target     out  32         redirect address
//  claim         out  1          1-cycle pulse to n_clic: clear pend of claim_id
//  claim_id      out  IdWidth    entry being claimed
//  cur_level     out  PrioWidth  active level, drives rf bank select
//  ra_we         out  1          write RetSentinel to ra of new bank
//  ra_data       out  32         = RetSentinel
//  stack_full    out  1          LIFO at StackDepth
// BEHAVIOUR
//  Reset: all outputs 0 except ra_data=RetSentinel; state RUN; LIFO empty; cur_level 0.
//  FSM RUN -> ENTER -> FLUSH -> RUN; RUN -> EXIT -> FLUSH -> RUN.
//  RUN: preempt if req_valid && req_level>cur_level && !stack_full && !stall -> ENTER.
//   equal/lower level never preempts; stack_full holds the request (no take, no claim).
//  ENTER (1 cycle): push {cur_level,pc_return}; take=claim=pc_redirect=ra_we=1;
//   pc_target=req_vec; claim_id=req_id; cur_level<=req_level, visible next cycle.
//  EXIT (1 cycle, from RUN on ret_valid && !stall): pop; pc_redirect=1,
//   pc_target=popped pc; cur_level<=popped level.
//  FLUSH: 1 bubble, no redirect, no new decision; lets the pipeline settle on the new bank.
//  Simultaneous ret_valid and eligible req in RUN: EXIT wins unless tail chain (below).
//  ret_valid with empty LIFO: ignored (no redirect, cur_level unchanged).
//  stall high: decision deferred; inputs resampled next cycle. ENTER/EXIT never stall.
//  Redirect latency: req seen in RUN cycle N -> pc_redirect in cycle N+1.
//  Reset mid-sequence: FSM, LIFO and cur_level clear immediately; no pulse completes.
//  Widths: levels compare unsigned; pc values pass unmodified; no arithmetic on PC.
// CONFIGURATION
//  CLIC_TAIL_CHAIN_EN defined:
//   - in RUN on ret_valid, if req_valid && req_level > top-of-stack level, do ENTER
//     without pop/push.
//   - keep the stacked return pc; pc_target=req_vec; cur_level<=req_level.
//   - take/claim/ra_we pulse as normal.
//  Undefined: ret always EXITs first; the pending req is taken after FLUSH on re-evaluation.
// STRUCTURE
//  config_pkg: PrioWidth, IdWidth, RetSentinel.
//  clic_ctrl_pkg:
//   - typedef enum {RUN,ENTER,EXIT,FLUSH} ctrl_state_t
//   - typedef struct packed {logic[PrioWidth-1:0] level; logic[31:0] pc;} stack_entry_t
//  Sub-module level_stack:
//   - parameterised LIFO of stack_entry_t with push/pop/top/full/empty
//   - push and pop never occur in the same cycle
// TESTING
//  1 req lvl3 vec 0x8C id1 at pc_return 0x1C, cur 0 -> take, pc_target 0x8C,
//    claim_id 1, cur_level 3 next cycle, ra_we.
//  2 inside lvl3 ISR, ret_valid -> pc_target 0x1C, cur_level 0, LIFO empty.
//  3 lvl2 active, req lvl5 -> nest (depth 2); req lvl2 or lvl1 -> no take;
//    two rets unwind 5->2->0 to correct pcs.
//  4 fill 7 nested entries (levels 1..7), force stack_full -> req held,
//    no claim; after ret, pending higher req is taken.
//  5 ret_valid at empty stack -> no redirect; stall=1 for 3 cycles with req -> take
//    one cycle after stall drops.
//  6 CLIC_TAIL_CHAIN_EN: lvl3 ret with req lvl2 pending over base 0 -> direct
//    pc_target=vec, stacked pc 0x1C kept; without macro: EXIT to 0x1C, then
//    ENTER after FLUSH; reset low mid-ENTER -> all outputs 0.

Source files
------------

// File: rtl/clic_preempt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clic_preempt_ctrl_pkg
// Shared configuration and types for the CLIC preemption controller.
//   PrioWidth   : priority/level width (register bank count = 2**PrioWidth)
//   IdWidth     : interrupt entry index width
//   StackDepth  : return LIFO depth (2**PrioWidth-1 covers strict nesting)
//   RetSentinel : value written to ra on entry; a jalr to it means "return"
//   ctrl_state_t  : controller sequencing states
//   stack_entry_t : one LIFO slot {previous level, return pc}
// -----------------------------------------------------------------------------
package clic_preempt_ctrl_pkg;

    localparam int          PrioWidth   = 3;
    localparam int          IdWidth     = 3;
    localparam int          StackDepth  = 7;
    localparam logic [31:0] RetSentinel = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        EXIT  = 2'd2,
        FLUSH = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic [PrioWidth-1:0] level;
        logic [31:0]          pc;
    } stack_entry_t;

endpackage

// File: rtl/clic_preempt_ctrl_level_stack.sv
// -----------------------------------------------------------------------------
// clic_preempt_ctrl_level_stack
// LIFO of {prev_level, return_pc} entries used to unwind nested interrupts.
// Push and pop are never requested in the same cycle by the controller.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset (empties the LIFO)
//   i_push          : write i_push_data on top (ignored when full)
//   i_pop           : discard the top entry (ignored when empty)
//   i_push_data     : entry to push
//   o_top           : current top entry (0 when empty)
//   o_full, o_empty : occupancy flags
// -----------------------------------------------------------------------------
module clic_preempt_ctrl_level_stack
    import clic_preempt_ctrl_pkg::*;
#(
    parameter int Depth = StackDepth
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  stack_entry_t i_push_data,
    output stack_entry_t o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_top_idx;
    stack_entry_t    r_mem [Depth];

    assign o_full    = (r_count == CntW'(Depth));
    assign o_empty   = (r_count == '0);
    assign w_top_idx = r_count - CntW'(1);
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx[IdxW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + CntW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CntW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[r_count[IdxW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/clic_preempt_ctrl.sv
// -----------------------------------------------------------------------------
// clic_preempt_ctrl
// Sequences interrupt entry/exit between the CLIC and the core datapath.
// Sequence: RUN -> ENTER -> FLUSH -> RUN (entry), RUN -> EXIT -> FLUSH -> RUN
// (return). The request is captured in the RUN decision cycle so ENTER drives
// stable values even if the CLIC changes its request meanwhile.
// Optional feature macro: CLIC_TAIL_CHAIN_EN (tail-chain a pending request on
// return instead of popping and re-entering).
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req_valid/level/id/vec : highest pending CLIC request
//   i_pc_return      : PC of oldest not-yet-executed instruction
//   i_ret_valid      : decoder saw jalr to RetSentinel
//   i_stall          : core cannot redirect this cycle
//   o_take, o_claim  : 1-cycle pulses on entry acceptance
//   o_claim_id       : entry being claimed
//   o_pc_redirect, o_pc_target : PC mux select and address
//   o_cur_level      : active level, register bank select
//   o_ra_we, o_ra_data : write RetSentinel to ra of new bank
//   o_stack_full     : return LIFO is full
// -----------------------------------------------------------------------------
module clic_preempt_ctrl
    import clic_preempt_ctrl_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    input  logic [PrioWidth-1:0] i_req_level,
    input  logic [IdWidth-1:0]   i_req_id,
    input  logic [31:0]          i_req_vec,
    input  logic [31:0]          i_pc_return,
    input  logic                 i_ret_valid,
    input  logic                 i_stall,
    output logic                 o_take,
    output logic                 o_pc_redirect,
    output logic [31:0]          o_pc_target,
    output logic                 o_claim,
    output logic [IdWidth-1:0]   o_claim_id,
    output logic [PrioWidth-1:0] o_cur_level,
    output logic                 o_ra_we,
    output logic [31:0]          o_ra_data,
    output logic                 o_stack_full
);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [PrioWidth-1:0] r_cur_level;
    logic [PrioWidth-1:0] r_req_level;
    logic [IdWidth-1:0]   r_req_id;
    logic [31:0]          r_req_vec;
    logic [31:0]          r_ret_pc;
    logic                 r_tail;

    logic                 w_enter_go;
    logic                 w_tail_go;
    logic                 w_ret_go;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    stack_entry_t         w_push_data;
    stack_entry_t         w_top;

    // A tail-chained entry reuses the stacked return context, so nothing is pushed.
    assign w_push      = (r_state == ENTER) && !r_tail;
    assign w_pop       = (r_state == EXIT);
    assign w_push_data = '{level: r_cur_level, pc: r_ret_pc};

    clic_preempt_ctrl_level_stack #(
        .Depth (StackDepth)
    ) u_level_stack (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_push_data),
        .o_top       (w_top),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // State register plus captured request and active level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= RUN;
            r_cur_level <= '0;
            r_req_level <= '0;
            r_req_id    <= '0;
            r_req_vec   <= '0;
            r_ret_pc    <= '0;
            r_tail      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_go || w_tail_go) begin
                r_req_level <= i_req_level;
                r_req_id    <= i_req_id;
                r_req_vec   <= i_req_vec;
                r_ret_pc    <= i_pc_return;
                r_tail      <= w_tail_go;
            end
            if (r_state == ENTER) begin
                r_cur_level <= r_req_level;
            end else if (r_state == EXIT) begin
                r_cur_level <= w_top.level;
            end
        end
    end

    // Next-state decision; only RUN looks at requests, and a return has priority.
    always_comb begin
        w_state_next = r_state;
        w_enter_go   = 1'b0;
        w_tail_go    = 1'b0;
        w_ret_go     = 1'b0;
        case (r_state)
            RUN: begin
                if (!i_stall) begin
                    if (i_ret_valid && !w_empty) begin
`ifdef CLIC_TAIL_CHAIN_EN
                        if (i_req_valid && (i_req_level > w_top.level)) begin
                            w_tail_go = 1'b1;
                        end else begin
                            w_ret_go = 1'b1;
                        end
`else
                        w_ret_go = 1'b1;
`endif
                    end else if (i_req_valid && (i_req_level > r_cur_level) && !w_full) begin
                        w_enter_go = 1'b1;
                    end
                end
                if (w_enter_go || w_tail_go) begin
                    w_state_next = ENTER;
                end else if (w_ret_go) begin
                    w_state_next = EXIT;
                end
            end
            ENTER:   w_state_next = FLUSH;
            EXIT:    w_state_next = FLUSH;
            FLUSH:   w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // Outputs are a pure function of state so reset clears them immediately.
    always_comb begin
        o_take        = 1'b0;
        o_claim       = 1'b0;
        o_claim_id    = '0;
        o_pc_redirect = 1'b0;
        o_pc_target   = '0;
        o_ra_we       = 1'b0;
        case (r_state)
            ENTER: begin
                o_take        = 1'b1;
                o_claim       = 1'b1;
                o_claim_id    = r_req_id;
                o_pc_redirect = 1'b1;
                o_pc_target   = r_req_vec;
                o_ra_we       = 1'b1;
            end
            EXIT: begin
                o_pc_redirect = 1'b1;
                o_pc_target   = w_top.pc;
            end
            default: begin
            end
        endcase
    end

    assign o_cur_level  = r_cur_level;
    assign o_ra_data    = RetSentinel;
    assign o_stack_full = w_full;

endmodule

// File: tb/tb_clic_preempt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clic_preempt_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level reference: a queue of saved contexts, the active level, and
// a scheduled "action next cycle, then one settle cycle" timeline.
// -----------------------------------------------------------------------------
module tb_clic_preempt_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_level;
    logic [2:0]  req_id;
    logic [31:0] req_vec;
    logic [31:0] pc_return;
    logic        ret_valid;
    logic        stall;
    logic        take;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        claim;
    logic [2:0]  claim_id;
    logic [2:0]  cur_level;
    logic        ra_we;
    logic [31:0] ra_data;
    logic        stack_full;

    clic_preempt_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_level   (req_level),
        .i_req_id      (req_id),
        .i_req_vec     (req_vec),
        .i_pc_return   (pc_return),
        .i_ret_valid   (ret_valid),
        .i_stall       (stall),
        .o_take        (take),
        .o_pc_redirect (pc_redirect),
        .o_pc_target   (pc_target),
        .o_claim       (claim),
        .o_claim_id    (claim_id),
        .o_cur_level   (cur_level),
        .o_ra_we       (ra_we),
        .o_ra_data     (ra_data),
        .o_stack_full  (stack_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CLIC_TAIL_CHAIN_EN
    localparam bit TailChain = 1'b1;
`else
    localparam bit TailChain = 1'b0;
`endif
    localparam int          Depth    = 7;
    localparam logic [31:0] Sentinel = 32'hFFFF_FFFF;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: saved contexts and the action scheduled for this cycle.
    typedef struct {
        int          level;
        logic [31:0] pc;
    } ctx_t;

    ctx_t        m_stk[$];
    int          m_cur;
    int          m_act;      // 0 none, 1 entry, 2 return
    bit          m_act_tail;
    int          m_act_level;
    int          m_act_id;
    logic [31:0] m_act_vec;
    logic [31:0] m_act_pc;
    bit          m_settle;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_cur      = 0;
        m_act      = 0;
        m_act_tail = 1'b0;
        m_settle   = 1'b0;
    endtask

    task automatic check_outputs();
        chk("take",        {31'd0, take},        {31'd0, m_act == 1});
        chk("claim",       {31'd0, claim},       {31'd0, m_act == 1});
        chk("ra_we",       {31'd0, ra_we},       {31'd0, m_act == 1});
        chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, m_act != 0});
        chk("claim_id",    {29'd0, claim_id},    (m_act == 1) ? 32'(m_act_id) : 32'd0);
        chk("pc_target",   pc_target,            (m_act == 1) ? m_act_vec :
                                                 (m_act == 2) ? m_act_pc : 32'd0);
        chk("cur_level",   {29'd0, cur_level},   32'(m_cur));
        chk("stack_full",  {31'd0, stack_full},  {31'd0, m_stk.size() == Depth});
        chk("ra_data",     ra_data,              Sentinel);
    endtask

    task automatic model_advance(input bit rv, input int lvl, input int id,
                                 input logic [31:0] vec, input logic [31:0] pc,
                                 input bit ret, input bit stl);
        ctx_t c;
        if (m_act == 1) begin
            if (!m_act_tail) begin
                c.level = m_cur;
                c.pc    = m_act_pc;
                m_stk.push_back(c);
            end
            $display("txn enter level %0d->%0d id %0d vec %h tail %0d depth %0d",
                     m_cur, m_act_level, m_act_id, m_act_vec, m_act_tail, m_stk.size());
            m_cur    = m_act_level;
            m_act    = 0;
            m_settle = 1'b1;
        end else if (m_act == 2) begin
            c = m_stk.pop_back();
            $display("txn return level %0d->%0d pc %h depth %0d",
                     m_cur, c.level, c.pc, m_stk.size());
            m_cur    = c.level;
            m_act    = 0;
            m_settle = 1'b1;
        end else if (m_settle) begin
            m_settle = 1'b0;
        end else if (!stl) begin
            if (ret && m_stk.size() > 0) begin
                if (TailChain && rv && lvl > m_stk[$].level) begin
                    m_act       = 1;
                    m_act_tail  = 1'b1;
                    m_act_level = lvl;
                    m_act_id    = id;
                    m_act_vec   = vec;
                end else begin
                    m_act       = 2;
                    m_act_pc    = m_stk[$].pc;
                end
            end else if (rv && lvl > m_cur && m_stk.size() < Depth) begin
                m_act       = 1;
                m_act_tail  = 1'b0;
                m_act_level = lvl;
                m_act_id    = id;
                m_act_vec   = vec;
                m_act_pc    = pc;
            end
        end
    endtask

    // One cycle: drive inputs just after the edge, check mid-cycle, advance model.
    task automatic step(input bit rv, input int lvl, input int id,
                        input logic [31:0] vec, input logic [31:0] pc,
                        input bit ret, input bit stl);
        req_valid = rv;
        req_level = 3'(lvl);
        req_id    = 3'(id);
        req_vec   = vec;
        pc_return = pc;
        ret_valid = ret;
        stall     = stl;
        @(negedge clk);
        check_outputs();
        model_advance(rv, lvl, id, vec, pc, ret, stl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'd0, 32'd0, 0, 0);
    endtask

    task automatic req(input int lvl, input int id, input logic [31:0] vec, input logic [31:0] pc);
        step(1, lvl, id, vec, pc, 0, 0);
    endtask

    task automatic ret1();
        step(0, 0, 0, 32'd0, 32'h0000_0BAD, 1, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_level = '0;
        req_id    = '0;
        req_vec   = '0;
        pc_return = '0;
        ret_valid = 1'b0;
        stall     = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single entry from base level
        req(3, 1, 32'h0000_008C, 32'h0000_001C);
        idle(3);
        chk("t1_level", {29'd0, cur_level}, 32'd3);

        // 2: return to base
        ret1();
        idle(3);
        chk("t2_level", {29'd0, cur_level}, 32'd0);

        // 3: nesting, non-preempting levels, ordered unwind
        req(2, 2, 32'h0000_0100, 32'h0000_0040);
        idle(2);
        req(5, 3, 32'h0000_0200, 32'h0000_0044);
        idle(2);
        chk("t3_nested", {29'd0, cur_level}, 32'd5);
        req(2, 4, 32'h0000_0300, 32'h0000_0048);
        req(1, 5, 32'h0000_0400, 32'h0000_004C);
        idle(1);
        ret1();
        idle(2);
        chk("t3_unwind1", {29'd0, cur_level}, 32'd2);
        ret1();
        idle(2);
        chk("t3_unwind0", {29'd0, cur_level}, 32'd0);

        // 4: fill all seven levels, full stack holds a request
        for (int l = 1; l <= 7; l++) begin
            req(l, l, 32'h0000_1000 + 32'(l * 16), 32'h0000_2000 + 32'(l * 4));
            idle(2);
        end
        chk("t4_full", {31'd0, stack_full}, 32'd1);
        for (int k = 0; k < 3; k++) req(7, 6, 32'h0000_3000, 32'h0000_3004);
        step(1, 7, 6, 32'h0000_3000, 32'h0000_3004, 1, 0);
        for (int k = 0; k < 4; k++) req(7, 6, 32'h0000_3000, 32'h0000_3004);
        idle(1);
        chk("t4_retaken", {29'd0, cur_level}, 32'd7);
        for (int k = 0; k < 8; k++) begin
            ret1();
            idle(2);
        end
        chk("t4_drained", {29'd0, cur_level}, 32'd0);

        // 5: return with empty stack, stalled request
        ret1();
        idle(1);
        for (int k = 0; k < 3; k++) step(1, 4, 2, 32'h0000_5000, 32'h0000_5004, 0, 1);
        req(4, 2, 32'h0000_5000, 32'h0000_5004);
        idle(3);
        ret1();
        idle(2);

        // 6: return with a pending lower-than-current request
        req(3, 1, 32'h0000_008C, 32'h0000_001C);
        idle(2);
        step(1, 2, 2, 32'h0000_0600, 32'h0000_0060, 1, 0);
        for (int k = 0; k < 4; k++) req(2, 2, 32'h0000_0600, 32'h0000_0060);
        idle(2);
        for (int k = 0; k < 4; k++) begin
            ret1();
            idle(2);
        end

        // Reset asserted during an entry cycle
        req(3, 5, 32'h0000_0500, 32'h0000_0070);
        rst_n = 1'b0;
        #1;
        chk("rst_take",     {31'd0, take},        32'd0);
        chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("rst_claim",    {31'd0, claim},       32'd0);
        chk("rst_ra_we",    {31'd0, ra_we},       32'd0);
        chk("rst_target",   pc_target,            32'd0);
        chk("rst_level",    {29'd0, cur_level},   32'd0);
        model_reset();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), $urandom, $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
